// File: rtl/enc1s_round_seq.sv
// One AES enc/dec or SM4 round on a 128-bit state, sequenced over a single
// 8->32 enc1s byte-op datapath (16 ops for AES, 4 for SM4).
module enc1s_round_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic         final_rnd,
   input  logic [127:0] state_in,
   input  logic [127:0] rkey_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] state_out
);

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned STATE_W = 128;
   localparam int unsigned CNT_W   = 4;

   localparam logic [1:0] MODE_AES_ENC = 2'b00;
   localparam logic [1:0] MODE_SM4     = 2'b10;
   localparam logic [1:0] MODE_RSVD    = 2'b11;

   localparam logic [7:0] SM4_SBOX [256] = '{
      8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
      8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
      8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
      8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
      8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
      8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
      8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
      8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
      8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
      8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
      8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
      8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
      8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
      8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
      8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   // GF(2^8) arithmetic over the AES polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r = r ^ p;
         p = xt(p);
      end
      return r;
   endfunction

   // a^254 is the multiplicative inverse (0 maps to 0)
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] aes_isbox(input logic [7:0] x);
      return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] rot_bytes(input logic [31:0] w, input logic [1:0] n);
      logic [31:0] r;
      case (n)
         2'd0:    r = w;
         2'd1:    r = {w[23:0], w[31:24]};
         2'd2:    r = {w[15:0], w[31:16]};
         default: r = {w[7:0],  w[31:8]};
      endcase
      return r;
   endfunction

   // Byte op: S-box on byte fn[1:0] of rs1, column/L transform, rotate into place, xor rs2.
   // SM4 L commutes with byte rotation, so all modes share the final rotate.
   function automatic logic [31:0] enc1s(input logic [4:0] fn, input logic [31:0] rs1,
                                         input logic [31:0] rs2);
      logic [7:0]  x;
      logic [7:0]  s;
      logic [31:0] v;
      logic [31:0] w;
      x = 8'(rs1 >> (8 * fn[1:0]));
      s = 8'h00;
      v = 32'h0;
      w = 32'h0;
      case (fn[4:3])
         2'b00: begin
            s = aes_sbox(x);
            w = fn[2] ? {24'h0, s} : {gmul(s, 8'h03), s, s, xt(s)};
         end
         2'b01: begin
            s = aes_isbox(x);
            w = fn[2] ? {24'h0, s}
                      : {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)};
         end
         2'b10: begin
            s = SM4_SBOX[x];
            v = {24'h0, s};
            w = fn[2] ? (v ^ {v[18:0], v[31:19]} ^ {v[8:0], v[31:9]})
                      : (v ^ {v[29:0], v[31:30]} ^ {v[21:0], v[31:22]}
                           ^ {v[13:0], v[31:14]} ^ {v[7:0], v[31:8]});
         end
         default: w = 32'h0;
      endcase
      return rs2 ^ rot_bytes(w, fn[1:0]);
   endfunction

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           mode_q, mode_d;
   logic                 fin_q, fin_d;
   logic [STATE_W-1:0]   st_q, st_d;
   logic [STATE_W-1:0]   rk_q, rk_d;
   logic [WORD_W-1:0]    acc_q, acc_d;
   logic [3*WORD_W-1:0]  stage_q, stage_d;
   logic [STATE_W-1:0]   out_q, out_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 accept_c;
   logic                 sm4_c;
   logic                 last_c;
   logic [1:0]           col_j_c, byte_i_c, src_col_c;
   logic [WORD_W-1:0]    rs1_c, rs2_c, res_c, t_c;

   assign sm4_c     = (mode_q == MODE_SM4);
   assign col_j_c   = cnt_q[3:2];
   assign byte_i_c  = cnt_q[1:0];
   assign src_col_c = (mode_q == MODE_AES_ENC) ? (col_j_c + byte_i_c) : (col_j_c - byte_i_c);
   assign last_c    = sm4_c ? (cnt_q == 4'd3) : (cnt_q == 4'd15);
   assign accept_c  = start && (mode != MODE_RSVD) && ((state_q == IDLE) || (state_q == DONE));
   assign t_c       = state_in[63:32] ^ state_in[95:64] ^ state_in[127:96] ^ rkey_in[31:0];

   // Operand selection: AES ShiftRows/InvShiftRows via column index, SM4 uses precomputed t
   always_comb begin
      rs1_c = rk_q[31:0];
      rs2_c = acc_q;
      if (sm4_c) begin
         if (byte_i_c == 2'd0) rs2_c = st_q[31:0];
      end else begin
         rs1_c = st_q[32*src_col_c +: 32];
         if (byte_i_c == 2'd0) rs2_c = rk_q[32*col_j_c +: 32];
      end
   end

   assign res_c = enc1s({mode_q, fin_q, byte_i_c}, rs1_c, rs2_c);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      fin_d   = fin_q;
      st_d    = st_q;
      rk_d    = rk_q;
      acc_d   = acc_q;
      stage_d = stage_q;
      out_d   = out_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept_c) begin
               state_d = RUN;
               cnt_d   = '0;
               mode_d  = mode;
               fin_d   = final_rnd;
               st_d    = state_in;
               rk_d    = {rkey_in[127:32], (mode == MODE_SM4) ? t_c : rkey_in[31:0]};
            end
         end
         RUN: begin
            if (last_c) begin
               state_d = DONE;
               cnt_d   = '0;
               out_d   = sm4_c ? {res_c, st_q[127:32]} : {res_c, stage_q};
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (byte_i_c == 2'd3) begin
                  case (col_j_c)
                     2'd0:    stage_d[31:0]  = res_c;
                     2'd1:    stage_d[63:32] = res_c;
                     2'd2:    stage_d[95:64] = res_c;
                     default: stage_d = stage_q;
                  endcase
               end else begin
                  acc_d = res_c;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= '0;
         fin_q   <= 1'b0;
         st_q    <= '0;
         rk_q    <= '0;
         acc_q   <= '0;
         stage_q <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         fin_q   <= fin_d;
         st_q    <= st_d;
         rk_q    <= rk_d;
         acc_q   <= acc_d;
         stage_q <= stage_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign state_out = out_q;

endmodule

// File: tb/tb_enc1s_round_seq.sv
// Directed bench for enc1s_round_seq: FIPS-197 round vectors, AES inverse,
// SM4 against a reference round model, handshake and mid-run reset.
module tb_enc1s_round_seq;

   localparam logic [7:0] SM4_S [256] = '{
      8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
      8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
      8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
      8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
      8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
      8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
      8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
      8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
      8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
      8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
      8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
      8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
      8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
      8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
      8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
   };

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [1:0]   mode;
   logic         final_rnd;
   logic [127:0] state_in;
   logic [127:0] rkey_in;
   logic         busy;
   logic         done;
   logic [127:0] state_out;

   int n_checks;
   int n_errors;

   enc1s_round_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .final_rnd (final_rnd),
      .state_in  (state_in),
      .rkey_in   (rkey_in),
      .busy      (busy),
      .done      (done),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte string as written in FIPS-197 (first byte leftmost) -> bus order (first byte at [7:0])
   function automatic logic [127:0] bs(input logic [127:0] x);
      logic [127:0] r;
      for (int n = 0; n < 16; n++) r[8*n +: 8] = x[8*(15-n) +: 8];
      return r;
   endfunction

   // Reference SM4 round word: X0 ^ L(tau(X1^X2^X3^rk)), L' for the key schedule
   function automatic logic [31:0] sm4_ref(input logic [31:0] x0, x1, x2, x3, rk, input logic key);
      logic [31:0] t;
      logic [31:0] b;
      t = x1 ^ x2 ^ x3 ^ rk;
      b = {SM4_S[t[31:24]], SM4_S[t[23:16]], SM4_S[t[15:8]], SM4_S[t[7:0]]};
      if (key) return x0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
      return x0 ^ b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]}
                ^ {b[7:0], b[31:8]};
   endfunction

   // Launch one round, scramble inputs once accepted, optionally poke start mid-run.
   // lat counts cycles from the accept cycle to the done cycle (0 on timeout).
   task automatic do_round(input logic [1:0] m, input logic f, input logic [127:0] s,
                           input logic [127:0] r, input int pulse_at,
                           output logic [127:0] res, output int lat);
      logic busy_bad;
      busy_bad  = 1'b0;
      mode      = m;
      final_rnd = f;
      state_in  = s;
      rkey_in   = r;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      state_in  = ~s;
      rkey_in   = ~r;
      final_rnd = ~f;
      mode      = 2'b00;
      lat       = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         start = (k == pulse_at);
         if (done) begin
            lat = k + 1;
            break;
         end
         if (busy !== 1'b1) busy_bad = 1'b1;
      end
      start = 1'b0;
      res   = state_out;
      check("busy_during_run", 128'(busy_bad), 128'(0));
   endtask

   logic [127:0] res, res2, prev;
   int           lat;
   logic [31:0]  x0, x1, x2, x3, rk;
   logic         any_resp, bb_bad, saw_done;
   int           dk[4];
   int           nd;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      mode      = 2'b00;
      final_rnd = 1'b0;
      state_in  = '0;
      rkey_in   = '0;
      #2;
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_done", 128'(done), 128'(0));
      check("reset_state_out", state_out, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 App. B round 1
      do_round(2'b00, 1'b0, bs(128'h193de3bea0f4e22b9ac68d2ae9f84808),
               bs(128'ha0fafe1788542cb123a339392a6c7605), 0, res, lat);
      check("aes_enc_latency", 128'(lat), 128'(17));
      check("aes_enc_round1", res, bs(128'ha49c7ff2689f352b6b5bea43026a5049));

      // FIPS-197 App. B final round
      do_round(2'b00, 1'b1, bs(128'heb40f21e592e38848ba113e71bc342d2),
               bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6), 0, res, lat);
      check("aes_final_latency", 128'(lat), 128'(17));
      check("aes_final_round", res, bs(128'h3925841d02dc09fbdc118597196a0b32));

      // Decrypt final round undoes encrypt final round when the key is zero
      do_round(2'b00, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h0, 0, res, lat);
      do_round(2'b01, 1'b1, res, 128'h0, 0, res2, lat);
      check("aes_dec_latency", 128'(lat), 128'(17));
      check("aes_dec_inverse", res2, 128'h00112233_44556677_8899aabb_ccddeeff);

      // SM4 cipher and key-schedule rounds
      x0 = 32'h01234567; x1 = 32'h89abcdef; x2 = 32'hfedcba98; x3 = 32'h76543210;
      rk = 32'hf12186f9;
      for (int f = 0; f < 2; f++) begin
         do_round(2'b10, f[0], {x3, x2, x1, x0}, {96'hdeadbeef_cafef00d_5a5a5a5a, rk}, 0, res, lat);
         check(f == 0 ? "sm4_latency" : "sm4k_latency", 128'(lat), 128'(5));
         check(f == 0 ? "sm4_round" : "sm4k_round", res,
               {sm4_ref(x0, x1, x2, x3, rk, f[0]), x3, x2, x1});
      end
      x0 = 32'ha5a5a5a5; x1 = 32'h0f1e2d3c; x2 = 32'h4b5a6978; x3 = 32'h8796a5b4;
      rk = 32'h3c3c0000;
      do_round(2'b10, 1'b0, {x3, x2, x1, x0}, {96'h0, rk}, 0, res, lat);
      check("sm4_round_b", res, {sm4_ref(x0, x1, x2, x3, rk, 1'b0), x3, x2, x1});

      // start pulsed during RUN must be ignored
      do_round(2'b00, 1'b0, bs(128'h193de3bea0f4e22b9ac68d2ae9f84808),
               bs(128'ha0fafe1788542cb123a339392a6c7605), 3, res, lat);
      check("start_in_run_latency", 128'(lat), 128'(17));
      check("start_in_run_result", res, bs(128'ha49c7ff2689f352b6b5bea43026a5049));

      // Reserved mode: no busy, no done, output held
      @(posedge clk); #1;
      prev     = state_out;
      any_resp = 1'b0;
      mode     = 2'b11;
      start    = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (busy || done) any_resp = 1'b1;
      end
      start = 1'b0;
      check("mode11_no_response", 128'(any_resp), 128'(0));
      check("mode11_output_held", state_out, prev);

      // start held high: back-to-back rounds, done every 17 cycles
      mode      = 2'b00;
      final_rnd = 1'b0;
      state_in  = bs(128'h193de3bea0f4e22b9ac68d2ae9f84808);
      rkey_in   = bs(128'ha0fafe1788542cb123a339392a6c7605);
      start     = 1'b1;
      bb_bad    = 1'b0;
      nd        = 0;
      @(posedge clk); #1;
      for (int k = 1; k <= 55; k++) begin
         @(posedge clk); #1;
         if (done && nd < 4) begin
            dk[nd] = k;
            nd++;
         end
         if (busy === done) bb_bad = 1'b1;
      end
      start = 1'b0;
      check("b2b_done_count", 128'(nd), 128'(3));
      check("b2b_first_done", 128'(dk[0]), 128'(16));
      check("b2b_gap1", 128'(dk[1] - dk[0]), 128'(17));
      check("b2b_gap2", 128'(dk[2] - dk[1]), 128'(17));
      check("b2b_busy_vs_done", 128'(bb_bad), 128'(0));
      check("b2b_result", state_out, bs(128'ha49c7ff2689f352b6b5bea43026a5049));
      repeat (20) @(posedge clk);
      #1;

      // Reset at RUN cycle 8 aborts the round
      mode     = 2'b00;
      state_in = bs(128'heb40f21e592e38848ba113e71bc342d2);
      rkey_in  = bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 128'(busy), 128'(0));
      check("rst_mid_done", 128'(done), 128'(0));
      check("rst_mid_state_out", state_out, 128'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("rst_no_done_after", 128'(saw_done), 128'(0));
      do_round(2'b00, 1'b1, bs(128'heb40f21e592e38848ba113e71bc342d2),
               bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6), 0, res, lat);
      check("rst_recover_latency", 128'(lat), 128'(17));
      check("rst_recover_result", res, bs(128'h3925841d02dc09fbdc118597196a0b32));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/enc1s_round_seq.md
Name: enc1s_round_seq

Overview:
- Sequencer that computes one full AES encrypt round, AES decrypt round, or SM4 round on a 128-bit state.
- Time-multiplexes a single internal enc1s combinational datapath, issuing one 8→32 byte-op per cycle.
- Sits between a block-cipher controller and enc1s, so a full round costs one enc1s instance plus accumulator registers.
- Used by the lightweight AES/SM4 hardware cores and as a golden sequencing model for software kernels.

Parameters:
- none. Widths are fixed by the enc1s datapath: 32-bit word, 128-bit state.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a round; sampled only in IDLE or DONE
- mode  in  2  00 AES enc, 01 AES dec, 10 SM4, 11 reserved
- final_rnd  in  1  drives enc1s fn[2]. AES: final round (no MixColumns). SM4: 1 = key-schedule L', 0 = cipher L.
- state_in  in  128  word j = bits [32j+31:32j]; byte 0 of word 0 = bits [7:0]
- rkey_in  in  128  AES: round-key words 0..3. SM4: rk = rkey_in[31:0], rest ignored.
- busy  out  1  high while the sequence runs
- done  out  1  one-cycle pulse; state_out is valid from this cycle
- state_out  out  128  round result, held until the next done

Behaviour:
- Reset: rst_n low asynchronously forces IDLE. busy=0, done=0, state_out=0, counter=0, accumulator=0.
- A reset mid-sequence aborts the round; no done is produced.
- States: IDLE, RUN, DONE.
- Accept condition: start=1 and mode≠11 in IDLE or DONE.
  - On accept, register mode, final_rnd, state_in and rkey_in; cnt←0; go to RUN.
  - Inputs are not sampled again until the next accept.
  - start with mode=11 is ignored: no busy, no done.
- RUN: busy=1. One enc1s op per cycle, result registered at the clock edge.
  - enc1s fn = {mode, final_rnd, i}, where i = byte index.
- AES (16 ops): cnt[3:2] = output column j, cnt[1:0] = i.
  - rs1 = S[(j+i) mod 4] for enc, S[(j−i) mod 4] for dec. This implements ShiftRows / InvShiftRows.
  - rs2 = RK[j] when i=0, otherwise the accumulator.
  - At i=3 the result is written to out word j; otherwise it goes to the accumulator.
- SM4 (4 ops):
  - At accept, precompute t = X1^X2^X3^rk, with Xk = state_in word k.
  - Op i: rs1 = t; rs2 = X0 when i=0, otherwise the accumulator.
  - After i=3: state_out = {X4, X3, X2, X1}, i.e. word0=X1, word1=X2, word2=X3, word3=X4.
- state_out changes only at the edge entering DONE. It is never partially visible, so out words are staged internally.
- After the last op, the FSM goes to DONE: done=1, busy=0 for exactly one cycle.
  - In DONE, an accepted start goes straight to RUN (back-to-back); otherwise go to IDLE.
  - Latency from the start-accept cycle to the done cycle: 17 cycles for AES, 5 for SM4.
- start while busy is ignored. Mode or input changes during RUN have no effect.
- Counter wraps only via the FSM: the terminal count is 15 for AES and 3 for SM4, with no overrun.

Test Plan:
- AES enc round (FIPS-197 App. B, round 1):
  - state_in bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, rkey bytes a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05, mode=00, final_rnd=0.
  - Byte order: state_in[7:0]=0x19.
  - Required: done at cycle 17; state_out bytes a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49.
- AES final round:
  - state_in bytes eb 40 f2 1e 59 2e 38 84 8b a1 13 e7 1b c3 42 d2, rkey bytes d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6, final_rnd=1.
  - Required: state_out bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
- AES decrypt inverse check:
  - Run the final round with rkey=0 on 0x00112233_44556677_8899aabb_ccddeeff, then mode=01, final_rnd=1, rkey=0 on that output.
  - Required: the original state is returned.
- SM4:
  - state_in words X0..X3 random, rk random, mode=10, final_rnd 0 and 1.
  - Required: done at cycle 5; words 0..2 = X1..X3; word 3 matches the bench model X0^L(τ(t)) or X0^L'(τ(t)).
- Handshake:
  - start held high continuously → back-to-back rounds with done every 17 cycles and busy low only in DONE.
  - start during RUN → ignored.
  - mode=11 → no response.
- Reset:
  - rst_n low at RUN cycle 8, released 2 cycles later.
  - Required: immediately busy=0, done=0, state_out=0; no done afterwards; the next start completes normally.
